rf_wb_ctrl: RTL and testbench
=============================

# rf_wb_ctrl

Write-back controller and hazard scoreboard for the core register file. It arbitrates the single register-file write port between the memory unit, the ALU and the debug interface. It drives the file's one-hot write enable, global write enable and data bus from a registered output stage, and tracks in-flight destination registers so that issue stalls on RAW/WAW hazards. It sits between the execute/memory stages and the register file.

## Interface
- RW, 16, register width
- REGNO, 8, number of registers
- REGNO_LOG, 3, register select width
- STARVE_MAX, 3, consecutive ALU losses before ALU gets forced priority (1..7)

- i_clk  in  1  core clock
- i_rst  in  1  reset; asynchronous, active-high
- i_iss_valid  in  1  instruction presented for issue
- i_iss_we  in  1  instruction writes rd
- i_iss_rd  in  REGNO_LOG  destination register
- i_iss_use1 / i_iss_use2  in  1 each  source operand 1/2 is read
- i_iss_src1 / i_iss_src2  in  REGNO_LOG each  source registers
- o_iss_stall  out  1  issue must hold (combinational)
- i_flush  in  1  pipeline flush; clears the scoreboard
- i_mem_valid, i_alu_valid, i_dbg_valid  in  1 each  write-back request
- i_mem_sel, i_alu_sel, i_dbg_sel  in  REGNO_LOG each  target register
- i_mem_d, i_alu_d, i_dbg_d  in  RW each  write data
- o_mem_ready, o_alu_ready, o_dbg_ready  out  1 each  grant (combinational)
- o_rf_ie  out  REGNO  one-hot write enable to the register file
- o_rf_gie  out  1  global write enable; equals |o_rf_ie
- o_rf_d  out  RW  write data to the register file
- o_busy  out  REGNO  scoreboard pending-write mask

## Operation
- Grant: at most one ready per cycle; a transfer is valid&ready at a rising edge.
- Priority: mem > alu > dbg. Exception: when stv == STARVE_MAX and i_alu_valid, ALU wins over mem.
- dbg is granted only when neither mem nor alu is valid.
- Starvation counter stv (3 bits):
  - increments, saturating at STARVE_MAX, on each edge where i_alu_valid and ALU is not granted;
  - clears when ALU is granted or i_alu_valid is low.
- Output stage, loaded every edge:
  - o_rf_ie = onehot(winner sel), o_rf_d = winner data;
  - with no winner, o_rf_ie = 0 and o_rf_d holds its previous value.
- Scoreboard busy[REGNO]:
  - Set busy[i_iss_rd] on an edge where i_iss_valid & i_iss_we & !o_iss_stall.
  - Clear busy[k] on an edge where o_rf_ie[k] is high and that write came from mem or alu. Track the source with a registered flag; dbg writes never clear.
  - i_flush clears all bits at the edge. Flush has priority over a same-edge set. An output-stage write already loaded still commits.
  - Set and clear of the same bit on one edge cannot occur (WAW stall). If forced, set wins.
- o_iss_stall = i_iss_valid & ((i_iss_use1 & busy[src1]) | (i_iss_use2 & busy[src2]) | (i_iss_we & busy[rd])).
- Write-back requests are not checked against the scoreboard. Writing a non-busy register is legal and clears nothing.

## Timing
- Reset (async): busy=0, stv=0, o_rf_ie=0, o_rf_gie=0, o_rf_d=0, source flag=0.
  - Ready outputs follow the valid inputs combinationally, also during reset.
  - An in-flight write is dropped.
- Latency from handshake edge E0:
  - o_rf_ie/o_rf_d are driven after E0;
  - the register file captures at E1;
  - the busy bit clears at E1;
  - o_iss_stall for that register drops in the cycle after E1;
  - a stalled reader sees the new value in that same cycle.
- Back-to-back: one write per cycle, sustained. o_rf_ie is never held more than one cycle for a single transfer.
- ready depends only on valids and stv, never on ready, so there is no combinational loop.

## Test plan
- Issue r3 with we=1, then issue with src1=3/use1=1 → stall high. ALU writes r3=0x1234 at E0 → o_rf_ie=0x08, o_rf_d=0x1234 after E0; busy[3]=0 and stall low after E1.
- mem and alu both valid for 6 cycles, STARVE_MAX=3 → grants mem, mem, mem, alu, mem, mem; stv returns to 0 after the ALU grant.
- dbg valid alongside alu → dbg ready low until alu drops. A dbg write to busy r5 leaves busy[5]=1.
- WAW: r2 busy, issue with rd=2, no sources used → stall until r2 commits. Issue and write-back on the same edge: the set wins and busy stays consistent.
- Set busy r1 and r6, assert i_flush alongside a pending write to r1 → busy=0 after the edge; r1 write still appears on o_rf_ie next cycle.
- Assert i_rst asynchronously mid-cycle with o_rf_ie=0x10 → o_rf_ie, o_rf_gie and o_busy go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rf_wb_ctrl_if.sv
// rf_wb_ctrl_if: issue, write-back request and register-file bundle for rf_wb_ctrl.
// Rev 1.0 - initial release.
`default_nettype none

interface rf_wb_ctrl_if #(
  parameter int RW        = 16,
  parameter int REGNO     = 8,
  parameter int REGNO_LOG = 3
);
  logic                 i_iss_valid;
  logic                 i_iss_we;
  logic [REGNO_LOG-1:0] i_iss_rd;
  logic                 i_iss_use1;
  logic                 i_iss_use2;
  logic [REGNO_LOG-1:0] i_iss_src1;
  logic [REGNO_LOG-1:0] i_iss_src2;
  logic                 o_iss_stall;
  logic                 i_flush;

  logic                 i_mem_valid;
  logic                 i_alu_valid;
  logic                 i_dbg_valid;
  logic [REGNO_LOG-1:0] i_mem_sel;
  logic [REGNO_LOG-1:0] i_alu_sel;
  logic [REGNO_LOG-1:0] i_dbg_sel;
  logic [RW-1:0]        i_mem_d;
  logic [RW-1:0]        i_alu_d;
  logic [RW-1:0]        i_dbg_d;
  logic                 o_mem_ready;
  logic                 o_alu_ready;
  logic                 o_dbg_ready;

  logic [REGNO-1:0]     o_rf_ie;
  logic                 o_rf_gie;
  logic [RW-1:0]        o_rf_d;
  logic [REGNO-1:0]     o_busy;

  modport slave (
    input  i_iss_valid, i_iss_we, i_iss_rd, i_iss_use1, i_iss_use2,
           i_iss_src1, i_iss_src2, i_flush,
           i_mem_valid, i_alu_valid, i_dbg_valid,
           i_mem_sel, i_alu_sel, i_dbg_sel,
           i_mem_d, i_alu_d, i_dbg_d,
    output o_iss_stall, o_mem_ready, o_alu_ready, o_dbg_ready,
           o_rf_ie, o_rf_gie, o_rf_d, o_busy
  );

  modport master (
    output i_iss_valid, i_iss_we, i_iss_rd, i_iss_use1, i_iss_use2,
           i_iss_src1, i_iss_src2, i_flush,
           i_mem_valid, i_alu_valid, i_dbg_valid,
           i_mem_sel, i_alu_sel, i_dbg_sel,
           i_mem_d, i_alu_d, i_dbg_d,
    input  o_iss_stall, o_mem_ready, o_alu_ready, o_dbg_ready,
           o_rf_ie, o_rf_gie, o_rf_d, o_busy
  );
endinterface

`default_nettype wire

// File: rtl/rf_wb_ctrl.sv
// ============================================================================
// rf_wb_ctrl: register-file write-port arbiter (mem/alu/dbg) with registered
// output stage and RAW/WAW hazard scoreboard for the issue stage.
// Rev 1.0 - initial release.
// ============================================================================
`default_nettype none

module rf_wb_ctrl #(
  parameter int RW         = 16,
  parameter int REGNO      = 8,
  parameter int REGNO_LOG  = 3,
  parameter int STARVE_MAX = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  rf_wb_ctrl_if.slave   bus
);

  localparam logic [2:0] c_STV_MAX = 3'(STARVE_MAX);

  logic [2:0]           r_stv;
  logic [REGNO-1:0]     r_busy;
  logic [REGNO-1:0]     r_rf_ie;
  logic [RW-1:0]        r_rf_d;
  logic                 r_src_clr;

  logic                 w_force_alu;
  logic                 w_mem_rdy;
  logic                 w_alu_rdy;
  logic                 w_dbg_rdy;
  logic                 w_win;
  logic [REGNO_LOG-1:0] w_win_sel;
  logic [RW-1:0]        w_win_d;
  logic [REGNO-1:0]     w_onehot;
  logic                 w_stall;
  logic                 w_iss_set;
  logic [REGNO-1:0]     w_busy_nxt;

  // Grants are a function of the valids and the starvation count only.
  assign w_force_alu = bus.i_alu_valid && (r_stv == c_STV_MAX);
  assign w_mem_rdy   = bus.i_mem_valid && !w_force_alu;
  assign w_alu_rdy   = bus.i_alu_valid && (w_force_alu || !bus.i_mem_valid);
  assign w_dbg_rdy   = bus.i_dbg_valid && !bus.i_mem_valid && !bus.i_alu_valid;
  assign w_win       = w_mem_rdy || w_alu_rdy || w_dbg_rdy;

  always_comb begin
    w_win_sel = bus.i_dbg_sel;
    w_win_d   = bus.i_dbg_d;
    if (w_mem_rdy) begin
      w_win_sel = bus.i_mem_sel;
      w_win_d   = bus.i_mem_d;
    end else if (w_alu_rdy) begin
      w_win_sel = bus.i_alu_sel;
      w_win_d   = bus.i_alu_d;
    end
  end

  assign w_onehot = {{(REGNO-1){1'b0}}, 1'b1} << w_win_sel;

  assign w_stall = bus.i_iss_valid &&
                   ((bus.i_iss_use1 && r_busy[bus.i_iss_src1]) ||
                    (bus.i_iss_use2 && r_busy[bus.i_iss_src2]) ||
                    (bus.i_iss_we   && r_busy[bus.i_iss_rd]));
  assign w_iss_set = bus.i_iss_valid && bus.i_iss_we && !w_stall;

  // Ordering gives set precedence over commit-clear, and flush over both.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_src_clr) begin
      w_busy_nxt = w_busy_nxt & ~r_rf_ie;
    end
    if (w_iss_set) begin
      w_busy_nxt[bus.i_iss_rd] = 1'b1;
    end
    if (bus.i_flush) begin
      w_busy_nxt = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stv     <= 3'd0;
      r_busy    <= '0;
      r_rf_ie   <= '0;
      r_rf_d    <= '0;
      r_src_clr <= 1'b0;
    end else begin
      if (bus.i_alu_valid && !w_alu_rdy) begin
        r_stv <= (r_stv == c_STV_MAX) ? r_stv : r_stv + 3'd1;
      end else begin
        r_stv <= 3'd0;
      end

      r_rf_ie   <= w_win ? w_onehot : '0;
      r_src_clr <= w_mem_rdy || w_alu_rdy;
      if (w_win) begin
        r_rf_d <= w_win_d;
      end

      r_busy <= w_busy_nxt;
    end
  end

  assign bus.o_mem_ready = w_mem_rdy;
  assign bus.o_alu_ready = w_alu_rdy;
  assign bus.o_dbg_ready = w_dbg_rdy;
  assign bus.o_iss_stall = w_stall;
  assign bus.o_rf_ie     = r_rf_ie;
  assign bus.o_rf_gie    = |r_rf_ie;
  assign bus.o_rf_d      = r_rf_d;
  assign bus.o_busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_ctrl.sv
// ============================================================================
// tb_rf_wb_ctrl: directed self-checking bench for rf_wb_ctrl.
// Rev 1.0 - initial release.
// ============================================================================
`default_nettype none

module tb_rf_wb_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  rf_wb_ctrl_if #(.RW(16), .REGNO(8), .REGNO_LOG(3)) bus ();

  rf_wb_ctrl #(.RW(16), .REGNO(8), .REGNO_LOG(3), .STARVE_MAX(3)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic iss(input logic v, input logic we, input logic [2:0] rd,
                     input logic u1, input logic [2:0] s1);
    bus.i_iss_valid = v;
    bus.i_iss_we    = we;
    bus.i_iss_rd    = rd;
    bus.i_iss_use1  = u1;
    bus.i_iss_src1  = s1;
    bus.i_iss_use2  = 1'b0;
    bus.i_iss_src2  = 3'd0;
  endtask

  logic [5:0] exp_alu;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    iss(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    bus.i_flush = 1'b0;
    bus.i_mem_valid = 1'b0; bus.i_alu_valid = 1'b0; bus.i_dbg_valid = 1'b0;
    bus.i_mem_sel = 3'd0; bus.i_alu_sel = 3'd0; bus.i_dbg_sel = 3'd0;
    bus.i_mem_d = 16'h0; bus.i_alu_d = 16'h0; bus.i_dbg_d = 16'h0;

    // Reset state and ready-during-reset
    tick();
    chk("rst_ie",   32'(bus.o_rf_ie), 32'h0);
    chk("rst_gie",  32'(bus.o_rf_gie), 32'h0);
    chk("rst_d",    32'(bus.o_rf_d), 32'h0);
    chk("rst_busy", 32'(bus.o_busy), 32'h0);
    bus.i_alu_valid = 1'b1;
    #1;
    chk("rst_alu_rdy", 32'(bus.o_alu_ready), 32'h1);
    bus.i_alu_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // RAW: issue r3 writer, reader stalls until ALU commit
    iss(1'b1, 1'b1, 3'd3, 1'b0, 3'd0);
    #1;
    chk("raw_iss_nostall", 32'(bus.o_iss_stall), 32'h0);
    tick();
    chk("raw_busy_set", 32'(bus.o_busy), 32'h08);
    iss(1'b1, 1'b0, 3'd0, 1'b1, 3'd3);
    #1;
    chk("raw_stall", 32'(bus.o_iss_stall), 32'h1);
    bus.i_alu_valid = 1'b1; bus.i_alu_sel = 3'd3; bus.i_alu_d = 16'h1234;
    #1;
    chk("raw_alu_rdy", 32'(bus.o_alu_ready), 32'h1);
    tick();
    bus.i_alu_valid = 1'b0;
    chk("raw_e0_ie",    32'(bus.o_rf_ie), 32'h08);
    chk("raw_e0_d",     32'(bus.o_rf_d), 32'h1234);
    chk("raw_e0_gie",   32'(bus.o_rf_gie), 32'h1);
    chk("raw_e0_stall", 32'(bus.o_iss_stall), 32'h1);
    tick();
    chk("raw_e1_busy",  32'(bus.o_busy), 32'h0);
    chk("raw_e1_stall", 32'(bus.o_iss_stall), 32'h0);
    chk("raw_e1_ie",    32'(bus.o_rf_ie), 32'h0);
    iss(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);

    // Starvation: mem and alu both valid six cycles
    exp_alu = 6'b001000;
    bus.i_mem_valid = 1'b1; bus.i_mem_sel = 3'd1; bus.i_mem_d = 16'hAAAA;
    bus.i_alu_valid = 1'b1; bus.i_alu_sel = 3'd2; bus.i_alu_d = 16'hBBBB;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("stv_mem_rdy%0d", i), 32'(bus.o_mem_ready), 32'(!exp_alu[i]));
      chk($sformatf("stv_alu_rdy%0d", i), 32'(bus.o_alu_ready), 32'(exp_alu[i]));
      tick();
      chk($sformatf("stv_ie%0d", i), 32'(bus.o_rf_ie), exp_alu[i] ? 32'h04 : 32'h02);
    end
    bus.i_mem_valid = 1'b0; bus.i_alu_valid = 1'b0;
    tick();
    chk("hold_ie", 32'(bus.o_rf_ie), 32'h0);
    chk("hold_d",  32'(bus.o_rf_d), 32'hAAAA);
    chk("hold_busy", 32'(bus.o_busy), 32'h0);

    // Debug arbitration and debug write does not clear busy
    iss(1'b1, 1'b1, 3'd5, 1'b0, 3'd0);
    tick();
    iss(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    chk("dbg_busy5", 32'(bus.o_busy), 32'h20);
    bus.i_dbg_valid = 1'b1; bus.i_dbg_sel = 3'd5; bus.i_dbg_d = 16'h5555;
    bus.i_alu_valid = 1'b1; bus.i_alu_sel = 3'd0; bus.i_alu_d = 16'h0F0F;
    #1;
    chk("dbg_rdy_low", 32'(bus.o_dbg_ready), 32'h0);
    chk("dbg_alu_rdy", 32'(bus.o_alu_ready), 32'h1);
    tick();
    bus.i_alu_valid = 1'b0;
    chk("dbg_alu_ie", 32'(bus.o_rf_ie), 32'h01);
    #1;
    chk("dbg_rdy_high", 32'(bus.o_dbg_ready), 32'h1);
    tick();
    bus.i_dbg_valid = 1'b0;
    chk("dbg_ie", 32'(bus.o_rf_ie), 32'h20);
    chk("dbg_d",  32'(bus.o_rf_d), 32'h5555);
    tick();
    chk("dbg_busy_kept", 32'(bus.o_busy), 32'h20);

    // WAW on r2
    iss(1'b1, 1'b1, 3'd2, 1'b0, 3'd0);
    tick();
    chk("waw_busy", 32'(bus.o_busy), 32'h24);
    #1;
    chk("waw_stall", 32'(bus.o_iss_stall), 32'h1);
    tick();
    chk("waw_stall_hold", 32'(bus.o_iss_stall), 32'h1);
    bus.i_mem_valid = 1'b1; bus.i_mem_sel = 3'd2; bus.i_mem_d = 16'h2222;
    tick();
    bus.i_mem_valid = 1'b0;
    chk("waw_e0_ie",    32'(bus.o_rf_ie), 32'h04);
    chk("waw_e0_stall", 32'(bus.o_iss_stall), 32'h1);
    tick();
    chk("waw_e1_busy",  32'(bus.o_busy), 32'h20);
    chk("waw_e1_stall", 32'(bus.o_iss_stall), 32'h0);
    tick();
    iss(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    chk("waw_reissue_busy", 32'(bus.o_busy), 32'h24);

    // Same-edge set and clear on r4: set wins
    bus.i_alu_valid = 1'b1; bus.i_alu_sel = 3'd4; bus.i_alu_d = 16'h4444;
    tick();
    bus.i_alu_valid = 1'b0;
    chk("setclr_ie", 32'(bus.o_rf_ie), 32'h10);
    iss(1'b1, 1'b1, 3'd4, 1'b0, 3'd0);
    #1;
    chk("setclr_nostall", 32'(bus.o_iss_stall), 32'h0);
    tick();
    iss(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    chk("setclr_busy", 32'(bus.o_busy), 32'h34);

    // Flush with pending write to r1 and a same-edge issue
    iss(1'b1, 1'b1, 3'd1, 1'b0, 3'd0);
    tick();
    iss(1'b1, 1'b1, 3'd6, 1'b0, 3'd0);
    tick();
    chk("fl_busy_pre", 32'(bus.o_busy), 32'h76);
    iss(1'b1, 1'b1, 3'd7, 1'b0, 3'd0);
    bus.i_flush = 1'b1;
    bus.i_mem_valid = 1'b1; bus.i_mem_sel = 3'd1; bus.i_mem_d = 16'h1111;
    tick();
    bus.i_flush = 1'b0; bus.i_mem_valid = 1'b0;
    iss(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    chk("fl_busy", 32'(bus.o_busy), 32'h0);
    chk("fl_ie",   32'(bus.o_rf_ie), 32'h02);
    chk("fl_d",    32'(bus.o_rf_d), 32'h1111);
    tick();
    chk("fl_busy_after", 32'(bus.o_busy), 32'h0);

    // Asynchronous reset mid-cycle
    bus.i_alu_valid = 1'b1; bus.i_alu_sel = 3'd4; bus.i_alu_d = 16'h9999;
    iss(1'b1, 1'b1, 3'd3, 1'b0, 3'd0);
    tick();
    bus.i_alu_valid = 1'b0;
    iss(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    chk("ar_pre_ie",   32'(bus.o_rf_ie), 32'h10);
    chk("ar_pre_busy", 32'(bus.o_busy), 32'h08);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_ie",   32'(bus.o_rf_ie), 32'h0);
    chk("ar_gie",  32'(bus.o_rf_gie), 32'h0);
    chk("ar_busy", 32'(bus.o_busy), 32'h0);
    chk("ar_d",    32'(bus.o_rf_d), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
